fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 64'h0, PC value loaded on reset.
REQ-002 SHALL provide parameter NOP_INSTR, default 32'h00000013, bubble instruction (addi x0,x0,0).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port stall  input  1  load-use hold request from hazard unit.
REQ-006 SHALL have port redirect  input  1  taken branch or jump, resolved downstream.
REQ-007 SHALL have port redirect_pc  input  64  branch target address.
REQ-008 SHALL have port imem_addr  output  64  instruction memory byte address, equal to current PC.
REQ-009 SHALL have port imem_instr  input  32  instruction memory read data, combinational from imem_addr.
REQ-010 SHALL have port PC_Out  output  64  current PC register.
REQ-011 SHALL have port IF_ID_PC_Out  output  64  PC of the latched instruction.
REQ-012 SHALL have port IF_ID_Instruction  output  32  latched instruction for the decode stage.
REQ-013 SHALL have port IF_ID_Valid  output  1  high when IF_ID_Instruction is a real fetched instruction.
REQ-014 SHALL have port fetch_count  output  32  count of valid instructions delivered to IF/ID.

Function
REQ-015 SHALL drive imem_addr combinationally from PC_Out, with no added latency.
REQ-016 SHALL apply a per-edge priority order: redirect, then stall, then normal advance.
REQ-017 SHALL, on a normal advance (redirect=0, stall=0), load PC<=PC+4, IF_ID_PC_Out<=PC, IF_ID_Instruction<=imem_instr, IF_ID_Valid<=1.
REQ-018 SHALL, on stall=1 with redirect=0, hold PC, IF_ID_PC_Out, IF_ID_Instruction, IF_ID_Valid and fetch_count unchanged.
REQ-019 SHALL, on redirect=1 regardless of stall, load PC<={redirect_pc[63:2],2'b00}, IF_ID_Instruction<=NOP_INSTR, IF_ID_Valid<=0, IF_ID_PC_Out<=0.
REQ-020 SHALL ignore redirect_pc[1:0] and force those bits to zero, so PC stays word-aligned.
REQ-021 SHALL wrap the PC modulo 2^64, so 64'hFFFFFFFFFFFFFFFC advances to 64'h0.
REQ-022 SHALL increment fetch_count by 1 on every edge that performs REQ-017, saturating at 32'hFFFFFFFF.
REQ-023 SHALL NOT increment fetch_count on stall edges, redirect edges, or while reset is asserted.
REQ-024 SHALL deliver a fetched instruction to IF/ID one cycle after its address is presented on imem_addr.
REQ-025 SHALL produce exactly one bubble (IF_ID_Valid=0) per redirect edge, and resume valid fetch from the target on the following non-stalled edge.
REQ-026 SHALL honour back-to-back redirects: each redirect edge loads its own target, and the last one wins.

Reset
REQ-027 SHALL asynchronously, on reset high, set PC=RESET_PC, IF_ID_PC_Out=0, IF_ID_Instruction=NOP_INSTR, IF_ID_Valid=0, fetch_count=0, with no clock required.
REQ-028 SHALL hold all outputs at their reset values while reset stays high, ignoring stall and redirect.
REQ-029 SHALL, on reset asserted mid-operation (including during stall or redirect), discard in-flight state; the first edge after deassertion performs REQ-016 from PC=RESET_PC.

Verification
REQ-030 SHALL cover sequential fetch: reset pulse then 4 free edges, imem returns addr-dependent words -> IF_ID_PC_Out 0,4,8,C with matching instructions, PC=0x10, fetch_count=4.
REQ-031 SHALL cover stall: stall=1 for 2 edges at PC=0x8 -> PC stays 0x8, IF/ID unchanged, fetch_count unchanged; after release the next edge latches PC 0x8 instruction.
REQ-032 SHALL cover redirect and stall together: redirect=1, stall=1, redirect_pc=0x103 -> PC=0x100, IF_ID_Instruction=0x00000013, IF_ID_Valid=0; the next free edge gives IF_ID_PC_Out=0x100 with Valid=1.
REQ-033 SHALL cover wrap: redirect to 0xFFFFFFFFFFFFFFFC then one free edge -> PC=0x0, IF_ID_PC_Out=0xFFFFFFFFFFFFFFFC.
REQ-034 SHALL cover asynchronous reset: assert reset between clock edges while PC=0x40 and fetch_count=16 -> immediately PC=0, fetch_count=0, IF_ID_Valid=0.
REQ-035 SHALL cover counter saturation: force fetch_count to 32'hFFFFFFFE via a long run, or a bench-only preload path, then 3 free edges -> fetch_count=32'hFFFFFFFF and held.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline latch and a saturating
// count of valid instructions delivered to decode.
module fetch_stage #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter logic [31:0] NOP_INSTR   = 32'h00000013,
    // Reset value of fetch_count; nonzero only to reach saturation quickly in simulation.
    parameter logic [31:0] COUNT_RESET = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [63:0] PC_Out,
    output logic [63:0] IF_ID_PC_Out,
    output logic [31:0] IF_ID_Instruction,
    output logic        IF_ID_Valid,
    output logic [31:0] fetch_count
);

    logic [63:0] r_pc;
    logic [63:0] r_ifid_pc;
    logic [31:0] r_ifid_instr;
    logic        r_ifid_valid;
    logic [31:0] r_fetch_count;

    logic [63:0] w_pc_next;
    logic [63:0] w_redirect_aligned;
    logic        w_advance;

    assign w_pc_next          = r_pc + 64'd4;
    assign w_redirect_aligned = {redirect_pc[63:2], 2'b00};
    assign w_advance          = !redirect && !stall;

    // Redirect outranks stall: a taken branch squashes the held instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_ifid_pc     <= 64'h0;
            r_ifid_instr  <= NOP_INSTR;
            r_ifid_valid  <= 1'b0;
            r_fetch_count <= COUNT_RESET;
        end else if (redirect) begin
            r_pc          <= w_redirect_aligned;
            r_ifid_pc     <= 64'h0;
            r_ifid_instr  <= NOP_INSTR;
            r_ifid_valid  <= 1'b0;
        end else if (w_advance) begin
            r_pc          <= w_pc_next;
            r_ifid_pc     <= r_pc;
            r_ifid_instr  <= imem_instr;
            r_ifid_valid  <= 1'b1;
            if (r_fetch_count != 32'hFFFFFFFF) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    assign imem_addr         = r_pc;
    assign PC_Out            = r_pc;
    assign IF_ID_PC_Out      = r_ifid_pc;
    assign IF_ID_Instruction = r_ifid_instr;
    assign IF_ID_Valid       = r_ifid_valid;
    assign fetch_count       = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall, redirect, wrap,
// asynchronous reset and counter saturation.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, stall, redirect;
    logic [63:0] redirect_pc;
    logic [63:0] imem_addr, PC_Out, IF_ID_PC_Out;
    logic [31:0] imem_instr, IF_ID_Instruction, fetch_count;
    logic        IF_ID_Valid;

    logic        reset2;
    logic [63:0] imem_addr2, PC_Out2, IF_ID_PC_Out2;
    logic [31:0] imem_instr2, IF_ID_Instruction2, fetch_count2;
    logic        IF_ID_Valid2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Address-dependent memory contents so each word is distinguishable.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A0000 ^ {a[63:32]};
    endfunction

    assign imem_instr  = mem_word(imem_addr);
    assign imem_instr2 = mem_word(imem_addr2);

    fetch_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .PC_Out(PC_Out), .IF_ID_PC_Out(IF_ID_PC_Out),
        .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_Valid(IF_ID_Valid),
        .fetch_count(fetch_count)
    );

    fetch_stage #(.COUNT_RESET(32'hFFFFFFFE)) dut_sat (
        .clk(clk), .reset(reset2), .stall(1'b0), .redirect(1'b0),
        .redirect_pc(64'h0), .imem_addr(imem_addr2), .imem_instr(imem_instr2),
        .PC_Out(PC_Out2), .IF_ID_PC_Out(IF_ID_PC_Out2),
        .IF_ID_Instruction(IF_ID_Instruction2), .IF_ID_Valid(IF_ID_Valid2),
        .fetch_count(fetch_count2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        stall = 1'b1; redirect = 1'b1; redirect_pc = 64'h1234;
        reset = 1'b1;
        #1;
        checks++; if (PC_Out !== 64'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", PC_Out); end
        checks++; if (IF_ID_PC_Out !== 64'h0) begin errors++; $display("FAIL reset_ifid_pc: got %h want 0", IF_ID_PC_Out); end
        checks++; if (IF_ID_Instruction !== 32'h00000013) begin errors++; $display("FAIL reset_instr: got %h want 00000013", IF_ID_Instruction); end
        checks++; if (IF_ID_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", IF_ID_Valid); end
        checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL reset_count: got %h want 0", fetch_count); end
        tick(); tick();
        checks++; if (PC_Out !== 64'h0 || IF_ID_Valid !== 1'b0 || fetch_count !== 32'h0)
            begin errors++; $display("FAIL reset_hold: pc %h valid %b count %h want 0/0/0", PC_Out, IF_ID_Valid, fetch_count); end
        checks++; if (imem_addr !== PC_Out) begin errors++; $display("FAIL imem_addr: got %h want %h", imem_addr, PC_Out); end
        stall = 1'b0; redirect = 1'b0; redirect_pc = 64'h0;
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (IF_ID_PC_Out !== 64'(4 * i) || IF_ID_Instruction !== mem_word(64'(4 * i)) || IF_ID_Valid !== 1'b1)
                begin errors++; $display("FAIL seq_ifid[%0d]: pc %h instr %h valid %b want %h %h 1",
                    i, IF_ID_PC_Out, IF_ID_Instruction, IF_ID_Valid, 64'(4 * i), mem_word(64'(4 * i))); end
        end
        checks++; if (PC_Out !== 64'h10) begin errors++; $display("FAIL seq_pc: got %h want 10", PC_Out); end
        checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL seq_count: got %0d want 4", fetch_count); end
        checks++; if (imem_addr !== 64'h10) begin errors++; $display("FAIL seq_imem_addr: got %h want 10", imem_addr); end
    endtask

    task automatic test_stall();
        do_reset();
        tick(); tick();
        stall = 1'b1;
        tick(); tick();
        checks++; if (PC_Out !== 64'h8) begin errors++; $display("FAIL stall_pc: got %h want 8", PC_Out); end
        checks++; if (IF_ID_PC_Out !== 64'h4 || IF_ID_Instruction !== mem_word(64'h4) || IF_ID_Valid !== 1'b1)
            begin errors++; $display("FAIL stall_ifid: pc %h instr %h valid %b want 4 %h 1", IF_ID_PC_Out, IF_ID_Instruction, IF_ID_Valid, mem_word(64'h4)); end
        checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL stall_count: got %0d want 2", fetch_count); end
        stall = 1'b0;
        tick();
        checks++; if (IF_ID_PC_Out !== 64'h8 || IF_ID_Instruction !== mem_word(64'h8) || PC_Out !== 64'hC || fetch_count !== 32'd3)
            begin errors++; $display("FAIL stall_release: ifid_pc %h instr %h pc %h count %0d want 8 %h C 3",
                IF_ID_PC_Out, IF_ID_Instruction, PC_Out, fetch_count, mem_word(64'h8)); end
    endtask

    task automatic test_redirect_stall();
        redirect = 1'b1; stall = 1'b1; redirect_pc = 64'h103;
        tick();
        redirect = 1'b0; stall = 1'b0;
        checks++; if (PC_Out !== 64'h100) begin errors++; $display("FAIL redir_pc: got %h want 100", PC_Out); end
        checks++; if (IF_ID_Instruction !== 32'h00000013 || IF_ID_Valid !== 1'b0 || IF_ID_PC_Out !== 64'h0)
            begin errors++; $display("FAIL redir_bubble: instr %h valid %b pc %h want 00000013 0 0", IF_ID_Instruction, IF_ID_Valid, IF_ID_PC_Out); end
        checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL redir_count: got %0d want 3", fetch_count); end
        tick();
        checks++; if (IF_ID_PC_Out !== 64'h100 || IF_ID_Valid !== 1'b1 || IF_ID_Instruction !== mem_word(64'h100) || fetch_count !== 32'd4)
            begin errors++; $display("FAIL redir_resume: pc %h valid %b instr %h count %0d want 100 1 %h 4",
                IF_ID_PC_Out, IF_ID_Valid, IF_ID_Instruction, fetch_count, mem_word(64'h100)); end
    endtask

    task automatic test_back_to_back();
        redirect = 1'b1; redirect_pc = 64'h200;
        tick();
        redirect_pc = 64'h302;
        tick();
        redirect = 1'b0;
        checks++; if (PC_Out !== 64'h300 || IF_ID_Valid !== 1'b0) begin errors++; $display("FAIL b2b_pc: pc %h valid %b want 300 0", PC_Out, IF_ID_Valid); end
        tick();
        checks++; if (IF_ID_PC_Out !== 64'h300 || IF_ID_Valid !== 1'b1 || PC_Out !== 64'h304)
            begin errors++; $display("FAIL b2b_resume: ifid_pc %h valid %b pc %h want 300 1 304", IF_ID_PC_Out, IF_ID_Valid, PC_Out); end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 64'hFFFFFFFFFFFFFFFF;
        tick();
        redirect = 1'b0;
        checks++; if (PC_Out !== 64'hFFFFFFFFFFFFFFFC) begin errors++; $display("FAIL wrap_align: got %h want FFFFFFFFFFFFFFFC", PC_Out); end
        tick();
        checks++; if (PC_Out !== 64'h0 || IF_ID_PC_Out !== 64'hFFFFFFFFFFFFFFFC || IF_ID_Instruction !== mem_word(64'hFFFFFFFFFFFFFFFC))
            begin errors++; $display("FAIL wrap: pc %h ifid_pc %h instr %h want 0 FFFFFFFFFFFFFFFC %h",
                PC_Out, IF_ID_PC_Out, IF_ID_Instruction, mem_word(64'hFFFFFFFFFFFFFFFC)); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 16; i++) tick();
        checks++; if (PC_Out !== 64'h40 || fetch_count !== 32'd16) begin errors++; $display("FAIL async_pre: pc %h count %0d want 40 16", PC_Out, fetch_count); end
        stall = 1'b1; redirect = 1'b1; redirect_pc = 64'h80;
        #2 reset = 1'b1;
        #1;
        checks++; if (PC_Out !== 64'h0 || fetch_count !== 32'h0 || IF_ID_Valid !== 1'b0 || IF_ID_Instruction !== 32'h00000013)
            begin errors++; $display("FAIL async_reset: pc %h count %0d valid %b instr %h want 0 0 0 00000013",
                PC_Out, fetch_count, IF_ID_Valid, IF_ID_Instruction); end
        #1 reset = 1'b0;
        stall = 1'b0; redirect = 1'b0;
        tick();
        checks++; if (IF_ID_PC_Out !== 64'h0 || IF_ID_Valid !== 1'b1 || PC_Out !== 64'h4 || fetch_count !== 32'd1)
            begin errors++; $display("FAIL async_resume: ifid_pc %h valid %b pc %h count %0d want 0 1 4 1",
                IF_ID_PC_Out, IF_ID_Valid, PC_Out, fetch_count); end
    endtask

    task automatic test_saturation();
        reset2 = 1'b0;
        checks++; if (fetch_count2 !== 32'hFFFFFFFE) begin errors++; $display("FAIL sat_preload: got %h want FFFFFFFE", fetch_count2); end
        tick();
        checks++; if (fetch_count2 !== 32'hFFFFFFFF) begin errors++; $display("FAIL sat_edge1: got %h want FFFFFFFF", fetch_count2); end
        tick(); tick();
        checks++; if (fetch_count2 !== 32'hFFFFFFFF || PC_Out2 !== 64'hC)
            begin errors++; $display("FAIL sat_hold: count %h pc %h want FFFFFFFF C", fetch_count2, PC_Out2); end
    endtask

    initial begin
        reset = 1'b1; reset2 = 1'b1;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 64'h0;
        #1;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_stall();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
